// File: rtl/tick_gen_pkg.sv
// Shared clock-rate constants and divisor helpers for the tick generator family.
// No timing or backpressure here; it holds constants only.
package tick_gen_pkg;

   localparam int unsigned CLK_FREQ_HZ = 100_000_000;
   localparam int          DEF_CNT_W   = 32;

   // Divisor giving one tick per period of rate_hz at the core clock rate.
   function automatic int unsigned rate_div(input int unsigned rate_hz);
      return CLK_FREQ_HZ / rate_hz;
   endfunction

   localparam int unsigned DIV_1HZ   = rate_div(1);
   localparam int unsigned DIV_2HZ   = rate_div(2);
   localparam int unsigned DIV_4HZ   = rate_div(4);
   localparam int unsigned DIV_500HZ = rate_div(500);

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divisor register plus wrap counter; first tick N edges after load/sync/reset.
// No backpressure: en only pauses the count. Square output exists under TICK_GEN_SQUARE_EN.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int          CNT_W   = DEF_CNT_W,
   parameter int unsigned RST_DIV = DIV_1HZ
)(
   input  logic             clk_100mhz,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   input  logic             load,
   input  logic             sync,
`ifdef TICK_GEN_SQUARE_EN
   output logic             sq,
`endif
   output logic             tick
);

   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_last;
   logic             wrap;

   // A zero divisor is treated as one, so the terminal count is never negative.
   assign div_last = (div_r == '0) ? '0 : (div_r - ONE);
   assign wrap     = (cnt >= div_last);

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         div_r <= RST_VAL;
         cnt   <= '0;
         tick  <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
         sq    <= 1'b0;
`endif
      end else if (load || sync) begin
         if (load) begin
            div_r <= div;
         end
         cnt   <= '0;
         tick  <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
         sq    <= 1'b0;
`endif
      end else if (en) begin
         if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
`ifdef TICK_GEN_SQUARE_EN
            sq   <= ~sq;
`endif
         end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/tick_gen.sv
// Bank of NUM_CH independent programmable tick channels sharing clock, reset and sync; registered outputs.
// No backpressure; optional square-wave outputs sq_o are built only when TICK_GEN_SQUARE_EN is defined.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int          NUM_CH  = 4,
   parameter int          CNT_W   = DEF_CNT_W,
   parameter int unsigned RST_DIV = DIV_1HZ
)(
   input  logic                    clk_100mhz,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en_i,
   input  logic [NUM_CH*CNT_W-1:0] div_i,
   input  logic [NUM_CH-1:0]       load_i,
   input  logic                    sync_i,
`ifdef TICK_GEN_SQUARE_EN
   output logic [NUM_CH-1:0]       sq_o,
`endif
   output logic [NUM_CH-1:0]       tick_o
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_chan #(
         .CNT_W   (CNT_W),
         .RST_DIV (RST_DIV)
      ) u_chan (
         .clk_100mhz (clk_100mhz),
         .rst        (rst),
         .en         (en_i[i]),
         .div        (div_i[i*CNT_W +: CNT_W]),
         .load       (load_i[i]),
         .sync       (sync_i),
`ifdef TICK_GEN_SQUARE_EN
         .sq         (sq_o[i]),
`endif
         .tick       (tick_o[i])
      );
   end

endmodule
